// File: rtl/reg_dump.sv
// Register-file dump engine: walks addresses FIRST..LAST, offering each value
// as a valid/ready beat while holding off CPU register writes.
module reg_dump #(
    parameter int         n     = 8,
    parameter logic [2:0] FIRST = 3'd1,
    parameter logic [2:0] LAST  = 3'd7
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                start,
    input  logic                abort,
    output logic [2:0]          Raddr,
    input  logic signed [n-1:0] Rdata,
    output logic signed [n-1:0] out_data,
    output logic [2:0]          out_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_addr, w_addr_nxt;
    logic signed [n-1:0] r_data, w_data_nxt;
    logic [2:0]          r_oaddr, w_oaddr_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_hold, w_hold_nxt;
    logic                w_handshake;

    assign w_handshake = r_valid & out_ready;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_addr  <= 3'd0;
            r_data  <= '0;
            r_oaddr <= 3'd0;
            r_valid <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_oaddr <= w_oaddr_nxt;
            r_valid <= w_valid_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_oaddr_nxt = r_oaddr;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                w_addr_nxt  = 3'd0;
                w_hold_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                if (start && !abort) begin
                    w_addr_nxt  = FIRST;
                    w_hold_nxt  = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_data_nxt  = Rdata;
                w_oaddr_nxt = r_addr;
                w_valid_nxt = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // LAST terminates the walk; the counter never wraps past it.
                if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    if (r_addr == LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_addr_nxt  = r_addr + 3'd1;
                        w_state_nxt = READ;
                    end
                end
            end
            DONE: begin
                w_hold_nxt  = 1'b0;
                w_addr_nxt  = 3'd0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_hold_nxt  = 1'b0;
            w_addr_nxt  = 3'd0;
        end
    end

    assign Raddr     = r_addr;
    assign out_data  = r_data;
    assign out_addr  = r_oaddr;
    assign out_valid = r_valid;
    assign cpu_hold  = r_hold;
    assign busy      = (r_state != IDLE);
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign done      = (r_state == DONE) && !abort;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: beat-level reference model with per-cycle comparison,
// directed scenarios with literal beat lists, then randomized traffic.
module tb_reg_dump;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic              start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [2:0]        Raddr, out_addr;
    logic signed [7:0] Rdata, out_data;
    logic              out_valid, cpu_hold, busy, done;
    logic signed [7:0] gpr [8];

    logic              start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
    logic [2:0]        Raddr1, out_addr1;
    logic signed [7:0] Rdata1, out_data1;
    logic              out_valid1, cpu_hold1, busy1, done1;
    logic signed [7:0] gpr1 [8];

    int n_pass = 0, n_total = 0;
    int dut_done_cnt = 0, dut_valid_cnt = 0;
    logic [10:0] beat_log [$];

    // reference model: dump progress tracked as "which register, which phase"
    logic              m_busy = 1'b0, m_capture = 1'b0, m_offer = 1'b0, m_finish = 1'b0;
    logic [2:0]        m_addr = 3'd0, m_oaddr = 3'd0;
    logic signed [7:0] m_data = 8'sd0;

    always #5 clk = ~clk;

    assign Rdata  = gpr[Raddr];
    assign Rdata1 = gpr1[Raddr1];

    reg_dump #(.n(8), .FIRST(3'd1), .LAST(3'd7)) u_dut (
        .clk(clk), .nReset(nReset), .start(start), .abort(abort),
        .Raddr(Raddr), .Rdata(Rdata), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .cpu_hold(cpu_hold),
        .busy(busy), .done(done)
    );

    reg_dump #(.n(8), .FIRST(3'd5), .LAST(3'd5)) u_one (
        .clk(clk), .nReset(nReset), .start(start1), .abort(abort1),
        .Raddr(Raddr1), .Rdata(Rdata1), .out_data(out_data1), .out_addr(out_addr1),
        .out_valid(out_valid1), .out_ready(ready1), .cpu_hold(cpu_hold1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_busy = 0; m_capture = 0; m_offer = 0; m_finish = 0;
            m_addr = 0; m_oaddr = 0; m_data = 0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1; m_addr = 3'd1; m_capture = 1;
            end
        end else if (abort) begin
            if (m_offer && out_ready) beat_log.push_back({m_oaddr, m_data});
            m_busy = 0; m_capture = 0; m_offer = 0; m_finish = 0; m_addr = 0;
        end else if (m_capture) begin
            m_data = gpr[m_addr]; m_oaddr = m_addr; m_offer = 1; m_capture = 0;
        end else if (m_offer) begin
            if (out_ready) begin
                beat_log.push_back({m_oaddr, m_data});
                m_offer = 0;
                if (m_addr == 3'd7) m_finish = 1;
                else begin m_addr = m_addr + 3'd1; m_capture = 1; end
            end
        end else if (m_finish) begin
            m_finish = 0; m_busy = 0; m_addr = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (nReset) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_finish && !abort});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_offer});
            chk("Raddr", {29'd0, Raddr}, {29'd0, m_addr});
            if (m_offer) begin
                chk("out_addr", {29'd0, out_addr}, {29'd0, m_oaddr});
                chk("out_data", {24'd0, out_data}, {24'd0, m_data});
            end
            if (done) dut_done_cnt++;
            if (out_valid) dut_valid_cnt++;
        end
    end

    task automatic preload();
        for (int i = 0; i < 8; i++) gpr[i] = 8'(i * 17);
    endtask

    task automatic clear_counts();
        beat_log.delete();
        dut_done_cnt = 0;
        dut_valid_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 300) begin @(negedge clk); k++; end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_full_log(input string name);
        chk({name, "_beats"}, beat_log.size(), 32'd7);
        for (int i = 0; i < 7 && i < beat_log.size(); i++)
            chk({name, "_beat"}, {21'd0, beat_log[i]}, {21'd0, 3'(i + 1), 8'((i + 1) * 17)});
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    initial begin
        int k;
        logic signed [7:0] cap_data;
        logic [2:0] cap_addr;
        int v1, d1;
        preload();
        for (int i = 0; i < 8; i++) gpr1[i] = 8'(i);
        gpr1[5] = 8'h80;
        #1;
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_addr", {29'd0, out_addr}, 32'd0);
        chk("rst_flags", {28'd0, out_valid, cpu_hold, busy, done}, 32'd0);
        chk("rst_Raddr", {29'd0, Raddr}, 32'd0);
        @(negedge clk); nReset = 1;

        // full dump with ready held high
        out_ready = 1; clear_counts();
        @(negedge clk); start = 1;
        k = 0;
        @(negedge clk); start = 0; k = 1;
        while (busy && k < 100) begin @(negedge clk); k++; end
        chk("full_cycles", k, 32'd16);
        check_full_log("full");
        chk("full_done_cnt", dut_done_cnt, 32'd1);
        chk("full_valid_cycles", dut_valid_cnt, 32'd7);
        chk("full_keep_data", {24'd0, out_data}, 32'h77);
        chk("full_hold_off", {31'd0, cpu_hold}, 32'd0);

        // consumer stall on beat 3
        clear_counts(); pulse_start();
        k = 0;
        while (!(out_valid && out_addr == 3'd3) && k < 50) begin @(negedge clk); k++; end
        out_ready = 0;
        repeat (5) @(negedge clk);
        chk("stall_addr", {29'd0, out_addr}, 32'd3);
        chk("stall_data", {24'd0, out_data}, 32'h33);
        out_ready = 1;
        wait_idle("stall");
        check_full_log("stall");
        chk("stall_valid_cycles", dut_valid_cnt, 32'd12);

        // abort during beat 4 (accepted in the same cycle)
        clear_counts(); pulse_start();
        k = 0;
        while (!(out_valid && out_addr == 3'd4) && k < 50) begin @(negedge clk); k++; end
        abort = 1;
        @(negedge clk); abort = 0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
        chk("abort_beats", beat_log.size(), 32'd4);
        repeat (3) @(negedge clk);
        chk("abort_no_done", dut_done_cnt, 32'd0);
        clear_counts(); pulse_start(); wait_idle("after_abort");
        check_full_log("after_abort");

        // asynchronous reset during beat 2
        clear_counts(); pulse_start();
        k = 0;
        while (!(out_valid && out_addr == 3'd2) && k < 50) begin @(negedge clk); k++; end
        #2 nReset = 0;
        #1;
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        chk("arst_out_addr", {29'd0, out_addr}, 32'd0);
        chk("arst_flags", {28'd0, out_valid, cpu_hold, busy, done}, 32'd0);
        chk("arst_Raddr", {29'd0, Raddr}, 32'd0);
        @(negedge clk); nReset = 1;
        clear_counts(); pulse_start(); wait_idle("after_rst");
        check_full_log("after_rst");

        // repeated start while busy
        clear_counts();
        for (int i = 0; i < 12; i++) begin @(negedge clk); start = ~start; end
        start = 0;
        wait_idle("restart");
        check_full_log("restart");
        chk("restart_done_cnt", dut_done_cnt, 32'd1);

        // single-register dump on the FIRST=LAST=5 instance
        v1 = 0; d1 = 0; cap_data = 0; cap_addr = 0;
        @(negedge clk); start1 = 1;
        @(negedge clk); start1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid1) begin v1++; cap_data = out_data1; cap_addr = out_addr1; end
            if (done1) d1++;
            @(negedge clk);
        end
        chk("one_beats", v1, 32'd1);
        chk("one_addr", {29'd0, cap_addr}, 32'd5);
        chk("one_data", 32'(int'(cap_data)), 32'(-128));
        chk("one_done", d1, 32'd1);
        chk("one_busy", {31'd0, busy1}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!cpu_hold) gpr[$urandom_range(0, 7)] = 8'($urandom);
        end
        start = 0; abort = 0; out_ready = 1;
        wait_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter n, default 8: data bus width, equal to the register file data width.
REQ-002 Parameter FIRST, default 1: first register address dumped (3-bit); %0 is skipped by default.
REQ-003 Parameter LAST, default 7: last register address dumped (3-bit); FIRST <= LAST SHALL be required.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  dump request, sampled in IDLE only.
REQ-007 abort  input  1  synchronous cancel of a dump in progress.
REQ-008 Raddr  output  3  read address driven to the register file read port.
REQ-009 Rdata  input  n  signed, combinational read data returned by the register file for Raddr.
REQ-010 out_data  output  n  signed captured register value.
REQ-011 out_addr  output  3  address of the register in out_data.
REQ-012 out_valid  output  1  out_data and out_addr are valid.
REQ-013 out_ready  input  1  consumer accepts the current beat.
REQ-014 cpu_hold  output  1  asserted while dumping, so the core suppresses register writes.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when a dump completes normally.

Function
REQ-017 FSM states SHALL be IDLE, READ, HOLD and DONE, with a 3-bit address counter addr; Raddr SHALL equal addr.
REQ-018 IDLE: addr=0 and cpu_hold=0; if start=1, SHALL load addr<=FIRST, set cpu_hold<=1 and go to READ.
REQ-019 READ (one cycle): SHALL register out_data<=Rdata, out_addr<=addr and out_valid<=1, then go to HOLD.
REQ-020 HOLD: out_valid=1, with out_data and out_addr stable until the handshake (out_valid & out_ready at a rising edge).
REQ-021 On handshake with addr==LAST: SHALL clear out_valid and go to DONE.
REQ-022 On handshake with addr!=LAST: SHALL clear out_valid, set addr<=addr+1 and go to READ.
REQ-023 Without a handshake, HOLD SHALL persist indefinitely with no timeout.
REQ-024 DONE: done=1 for exactly one cycle, cpu_hold<=0 and addr<=0, then go to IDLE.
REQ-025 out_valid SHALL be low in every cycle outside HOLD, so there are no back-to-back beats.
REQ-026 Minimum time per beat is 2 cycles; a full default dump takes 16 cycles from the start edge back to IDLE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start and abort both high in IDLE: abort wins and the state remains IDLE.
REQ-029 abort=1 in READ, HOLD or DONE: next state IDLE, with out_valid, cpu_hold, done and addr all cleared, and no done pulse. An accepted beat in the same cycle still counts as consumed.
REQ-030 out_ready asserted outside HOLD SHALL have no effect.
REQ-031 FIRST==LAST: exactly one beat followed by DONE.
REQ-032 The address counter SHALL never wrap; LAST=7 ends the dump and does not increment to 0.
REQ-033 out_data SHALL keep its last captured value after the dump ends; only out_valid qualifies it.

Reset
REQ-034 nReset=0 SHALL immediately, without waiting for clk, force IDLE, addr=0, out_data=0, out_addr=0, and out_valid, cpu_hold, busy and done all 0.
REQ-035 Reset mid-dump SHALL discard progress; the first start after release begins again at FIRST.
REQ-036 The first rising edge after nReset goes high SHALL evaluate IDLE normally, so start sampled on that edge is honoured.

Verification
REQ-037 Preload gpr1..gpr7=8'h11..8'h77, pulse start, hold out_ready=1 -> beats (1,11)..(7,77), each valid one cycle, one cycle gap between beats, done after the 7th accept, busy low 16 cycles after start.
REQ-038 Same preload, out_ready=0 for 5 cycles on beat 3 -> out_valid held with (3,33) stable throughout, no skipped or duplicated beats.
REQ-039 abort asserted in HOLD of beat 4 -> IDLE next cycle, no done pulse, cpu_hold=0; a new start yields a beat sequence beginning at (1,11).
REQ-040 nReset pulsed low between clock edges during beat 2 -> all outputs 0 immediately; a dump after release is complete and correct.
REQ-041 FIRST=LAST=5, gpr5=8'h80 -> a single beat (5,-128), then done.
REQ-042 start pulsed repeatedly during a dump -> exactly one 7-beat sequence and one done pulse.
